div_arbiter: RTL
================

// Module: div_arbiter
// PURPOSE
//   Shares one 32-bit divider between NREQ requesters (CPU ALU, DMA/coprocessor ports).
//   Round-robin arbitration, operand capture, one-cycle go to the divider, wait for its
//   available pulse, result returned to the granted requester with a one-cycle done pulse.
//   Sits between the requesters and the divider; the divider sees a single master.
// PARAMETERS
//   NREQ     2    number of requesters, 2..4
//   TIMEOUT  127  max cycles in WAIT before forced completion with error (>= 80)
// PORTS
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high reset
//   req          in   NREQ     request level per requester; hold until ack
//   req_a        in   32*NREQ  dividend, slice i = [32*i+31:32*i]
//   req_b        in   32*NREQ  divisor, same slicing
//   req_divs     in   NREQ     signed-mode flag per requester
//   req_rem      in   NREQ     1 = return remainder, 0 = quotient
//   ack          out  NREQ     one-cycle pulse: request accepted, operands captured
//   done         out  NREQ     one-cycle pulse: result/flags valid for requester i
//   result       out  32       last completed result, held until next completion
//   res_zero     out  1        divider is_zero, latched with result
//   res_neg      out  1        divider is_negative, latched with result
//   res_dz       out  1        1 = captured divisor was 0
//   res_err      out  1        1 = completion forced by timeout
//   busy         out  1        1 in any state except IDLE
//   div_a/div_b  out  32 each  registered operands to divider
//   div_divs     out  1        registered; stable from ISSUE until return to IDLE
//   div_rem      out  1        registered; stable from ISSUE until return to IDLE
//   div_go       out  1        one-cycle start pulse to divider
//   div_c        in   32       divider result (combinational in div_divs/div_rem)
//   div_zero     in   1        divider is_zero
//   div_neg      in   1        divider is_negative
//   div_available in  1        divider one-cycle completion pulse
// BEHAVIOUR
//   Reset: state IDLE; ack, done, div_go, busy, res_* and result = 0; div_a/div_b/div_divs/
//     div_rem = 0; last-grant pointer = NREQ-1 (requester 0 wins first); wait counter = 0.
//   States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE: if any req, pick first set bit scanning from last+1 modulo NREQ; at that edge
//     capture slice into div_*, ack[g]<=1, div_go<=1, last<=g, go ISSUE. No req: stay.
//   ISSUE (1 cycle): ack and div_go high exactly this cycle; clear wait counter; -> WAIT.
//   WAIT: div_available sampled only here. On 1: result<=div_c, res_zero<=div_zero,
//     res_neg<=div_neg, res_dz<=(div_b==0), res_err<=0, done[g]<=1, -> DONE.
//     Counter reaches TIMEOUT without pulse: result<=0, res_err<=1, res_dz as above,
//     done[g]<=1, -> DONE. div_available outside WAIT is ignored.
//   DONE (1 cycle): done[g] high this cycle only; -> IDLE. New arbitration in IDLE
//     the following cycle; minimum issue-to-issue spacing = completion latency + 2.
//   Latency: req seen at edge T -> ack/go in cycle T+1; divide-by-zero done in T+4;
//     normal divide done <= T+72.
//   req dropped before ack: ignored, no ack. req still high in ack cycle (and the next,
//     from a slow requester) not re-granted until IDLE; requester must drop req after ack.
//   Only granted index g ever sees ack/done; all other bits stay 0.
//   reset mid-operation: immediate return to IDLE, no done issued; the divider is
//     re-synchronised by the next div_go (divider go overrides its state).
//   No data width changes: operands/results pass through unmodified at 32 bits.
// TESTING
//   reset, req[0]=1 a=100 b=7 divs=0 rem=0 -> ack[0] 1 cycle later, done[0], result=14
//   same with rem=1 -> result=2, res_zero=0; a=21 b=7 rem=1 -> result=0, res_zero=1
//   req[0] a=7 b=0 -> res_dz=1, done[0] 4 cycles after req edge, res_err=0
//   req[0],req[1] held high continuously, re-raised after each ack, for 4 ops ->
//     grant order 0,1,0,1; never two acks in flight
//   divider model with div_available stuck 0 -> done after TIMEOUT=127 WAIT cycles,
//     res_err=1, result=0; next request completes normally with res_err=0
//   reset asserted in WAIT -> busy=0 next cycle, no done; subsequent 100/7 returns 14

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one 32-bit divider between NREQ requesters
module div_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 127
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]    req_divs,
    input  logic [NREQ-1:0]    req_rem,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    done,
    output logic [31:0]        result,
    output logic               res_zero,
    output logic               res_neg,
    output logic               res_dz,
    output logic               res_err,
    output logic               busy,
    output logic [31:0]        div_a,
    output logic [31:0]        div_b,
    output logic               div_divs,
    output logic               div_rem,
    output logic               div_go,
    input  logic [31:0]        div_c,
    input  logic               div_zero,
    input  logic               div_neg,
    input  logic               div_available
);
    localparam int LW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic [LW-1:0]   last, g;
    logic [CW-1:0]   cnt;
    logic            any, tmo, finish;
    int              idx;

    assign any    = |req;
    assign busy   = state != IDLE;
    assign tmo    = cnt == CW'(TIMEOUT - 1);
    assign finish = state == WAIT && (div_available || tmo);

    // round-robin pick: first requester after the last grant, lowest distance wins
    always_comb begin
        g   = last;
        idx = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[LW'(idx)]) g = LW'(idx);
        end
    end

    // next-state sequencing through one divide transaction
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = finish ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // operand capture, handshake pulses, wait timer and result latching
    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= '0;
            done     <= '0;
            div_go   <= 1'b0;
            div_a    <= '0;
            div_b    <= '0;
            div_divs <= 1'b0;
            div_rem  <= 1'b0;
            last     <= LW'(NREQ - 1);
            cnt      <= '0;
            result   <= '0;
            res_zero <= 1'b0;
            res_neg  <= 1'b0;
            res_dz   <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            ack    <= '0;
            done   <= '0;
            div_go <= 1'b0;
            cnt    <= state == WAIT ? cnt + 1'b1 : '0;
            if (state == IDLE && any) begin
                div_a    <= req_a[32*g +: 32];
                div_b    <= req_b[32*g +: 32];
                div_divs <= req_divs[g];
                div_rem  <= req_rem[g];
                ack      <= NREQ'(1) << g;
                div_go   <= 1'b1;
                last     <= g;
            end
            if (finish) begin
                result   <= div_available ? div_c : '0;
                res_zero <= div_available & div_zero;
                res_neg  <= div_available & div_neg;
                res_dz   <= div_b == '0;
                res_err  <= ~div_available;
                done     <= NREQ'(1) << last;
            end
        end
    end
endmodule
